// File: rtl/kernel_pkg.sv
// Shared constants and types for the kernel coefficient bank and its load controller.
package kernel_pkg;
    localparam int unsigned DEF_KER_SIZE = 3;
    localparam int unsigned DEF_NUM_KER  = 4;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned SLOT_W       = $clog2(DEF_NUM_KER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } kerState_e;

    typedef logic [SLOT_W-1:0] slotIdx_t;
endpackage

// File: rtl/kernel_bank.sv
// NUM_KER whole-kernel register slots: one full-kernel write port, one registered read port.
module kernel_bank #(
    parameter int unsigned NUM_KER  = kernel_pkg::DEF_NUM_KER,
    parameter int unsigned NUM_COEF = kernel_pkg::DEF_KER_SIZE * kernel_pkg::DEF_KER_SIZE,
    parameter int unsigned DATA_W   = kernel_pkg::DEF_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wrEn,
    input  logic [$clog2(NUM_KER)-1:0]           wrSel,
    input  logic [NUM_COEF-1:0][DATA_W-1:0]      wrData,
    input  logic [$clog2(NUM_KER)-1:0]           rdSel,
    output logic [NUM_COEF-1:0][DATA_W-1:0]      rdData
);
    logic [NUM_COEF-1:0][DATA_W-1:0] mem [NUM_KER];

    // A write is seen by the read port one cycle after it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_KER); i++) begin
                mem[i] <= '0;
            end
            rdData <= '0;
        end else begin
            if (wrEn) begin
                mem[wrSel] <= wrData;
            end
            rdData <= mem[rdSel];
        end
    end
endmodule

// File: rtl/kernel_bank_ctrl.sv
// Byte-stream kernel loader with shadow buffer; commits to the bank slot unless that
// slot is the one driving a busy frame, in which case the commit waits for frame end.
module kernel_bank_ctrl
    import kernel_pkg::*;
#(
    parameter int unsigned KER_SIZE = DEF_KER_SIZE,
    parameter int unsigned NUM_KER  = DEF_NUM_KER,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_start,
    input  logic [$clog2(NUM_KER)-1:0]    ld_sel,
    input  logic                          ld_valid,
    input  logic [DATA_W-1:0]             ld_data,
    output logic                          ld_ready,
    output logic                          ld_done,
    input  logic                          frame_start,
    input  logic [$clog2(NUM_KER)-1:0]    frm_sel,
    input  logic                          frame_busy,
    output logic                          k_valid,
    output logic [DATA_W-1:0]             k0,
    output logic [DATA_W-1:0]             k1,
    output logic [DATA_W-1:0]             k2,
    output logic [DATA_W-1:0]             k3,
    output logic [DATA_W-1:0]             k4,
    output logic [DATA_W-1:0]             k5,
    output logic [DATA_W-1:0]             k6,
    output logic [DATA_W-1:0]             k7,
    output logic [DATA_W-1:0]             k8
);
    localparam int unsigned NUM_COEF = KER_SIZE * KER_SIZE;
    localparam int unsigned SEL_W    = $clog2(NUM_KER);
    localparam int unsigned CNT_W    = $clog2(NUM_COEF + 1);

    kerState_e                     state;
    kerState_e                     nextState;
    logic [SEL_W-1:0]              tgt;
    logic [SEL_W-1:0]              curSel;
    logic [CNT_W-1:0]              cnt;
    logic [NUM_COEF-1:0][DATA_W-1:0] shadow;
    logic [NUM_COEF-1:0][DATA_W-1:0] rdData;

    logic loadGo;
    logic beatAcc;
    logic commit;
    logic lastBeat;
    logic commitOk;

    assign lastBeat = (cnt == CNT_W'(NUM_COEF - 1));
    assign commitOk = (tgt != curSel) || !frame_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (ld_start) nextState = LOAD;
            LOAD:    if (ld_valid && lastBeat) nextState = PEND;
            PEND:    if (commitOk) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        loadGo  = 1'b0;
        beatAcc = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE:    loadGo  = ld_start;
            LOAD:    beatAcc = ld_valid;
            PEND:    commit  = commitOk;
            default: ;
        endcase
    end

    // Shadow fill, slot tracking and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt      <= '0;
            cnt      <= '0;
            shadow   <= '0;
            curSel   <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            k_valid  <= 1'b0;
        end else begin
            if (loadGo) begin
                tgt <= ld_sel;
                cnt <= '0;
            end
            if (beatAcc) begin
                shadow[cnt] <= ld_data;
                cnt         <= cnt + CNT_W'(1);
            end
            if (frame_start) begin
                curSel <= frm_sel;
            end
            ld_ready <= (nextState == LOAD);
            ld_done  <= commit;
            // Outputs lag the bank by one read cycle after a slot switch or a live rewrite.
            k_valid  <= !(frame_start || (commit && (tgt == curSel)));
        end
    end

    kernel_bank #(
        .NUM_KER  (NUM_KER),
        .NUM_COEF (NUM_COEF),
        .DATA_W   (DATA_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (commit),
        .wrSel  (tgt),
        .wrData (shadow),
        .rdSel  (curSel),
        .rdData (rdData)
    );

    assign k0 = rdData[0];
    assign k1 = rdData[1];
    assign k2 = rdData[2];
    assign k3 = rdData[3];
    assign k4 = rdData[4];
    assign k5 = rdData[5];
    assign k6 = rdData[6];
    assign k7 = rdData[7];
    assign k8 = rdData[8];
endmodule

// File: doc/kernel_bank_ctrl.md
# kernel_bank_ctrl

Controller and storage for the convolution kernel coefficients. It accepts kernels over a byte-stream load port into a shadow buffer and commits each complete kernel into one of NUM_KER bank slots. It presents the nine coefficients of the active kernel, registered, to the convolution datapath. A commit to the kernel in use is held off until the current frame ends, so the datapath never sees a partially updated kernel.

## Interface
Parameters:
- KER_SIZE, 3, kernel edge length; coefficients per kernel = KER_SIZE*KER_SIZE (9)
- NUM_KER, 4, number of bank slots
- DATA_W, 8, coefficient width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_start  in  1  one-cycle request to begin a kernel load; honoured only in IDLE
- ld_sel  in  2  target slot, sampled with ld_start
- ld_valid  in  1  coefficient beat valid
- ld_data  in  DATA_W  coefficient, row-major order (k0 first)
- ld_ready  out  1  beat accepted when ld_valid && ld_ready
- ld_done  out  1  one-cycle pulse after a kernel is written to the bank
- frame_start  in  1  one-cycle pulse from the conv engine; latches frm_sel
- frm_sel  in  2  slot to use for the starting frame
- frame_busy  in  1  high while the conv engine processes a frame
- k_valid  out  1  k0..k8 match the bank contents for cur_sel
- k0..k8  out  DATA_W each  active kernel coefficients, registered

## Operation
- FSM states:
  - IDLE: ld_start -> LOAD; tgt <= ld_sel; beat count <= 0.
  - LOAD: ld_ready = 1. Each accepted beat writes shadow[cnt] and increments cnt. The 9th accepted beat -> PEND.
  - PEND: commit condition is (tgt != cur_sel) || !frame_busy. When true, bank[tgt] <= shadow at that edge and the FSM returns to IDLE. Otherwise the FSM stays in PEND.
- ld_done is registered high in the cycle after the bank write.
- ld_start outside IDLE is ignored. ld_ready is low in IDLE and PEND.
- cur_sel <= frm_sel on every frame_start, in any FSM state.
- k0..k8 <= bank[cur_sel] every cycle (registered read).
- k_valid:
  - Cleared by frame_start.
  - Set again one cycle later.
  - Also cleared in the cycle following a write to bank[cur_sel].
- Simultaneous events:
  - PEND commit and frame_start with frm_sel == tgt at the same edge: both take effect. The outputs update one cycle later with the new coefficients.
  - frame_busy rising in PEND while tgt == cur_sel: the commit waits.
- Reset, including mid-load:
  - FSM -> IDLE; cnt = 0; shadow, bank, cur_sel and k0..k8 = 0.
  - ld_ready = 0, ld_done = 0, k_valid = 0.
  - A partially loaded kernel is discarded.
- Coefficients are opaque DATA_W bit patterns; no arithmetic is performed on them.

## Timing
- ld_start sampled at edge T: ld_ready high from T+1.
- Minimum load is 9 cycles with ld_valid held high; the last beat is accepted at edge A.
- If the commit condition holds, the FSM is in PEND during cycle A..A+1. The bank is written at edge A+1, ld_done is high for A+1..A+2, and the FSM is in IDLE from A+1.
- A new ld_start is accepted from A+1.
- frame_start sampled at edge F: cur_sel updates at F; k0..k8 and k_valid valid from edge F+1.
- The bank write at edge E to slot cur_sel is visible on k0..k8 from E+1.
- Any ld_valid gap simply stalls LOAD. There is no timeout.

## Structure
- Shared package kernel_pkg holds:
  - KER_SIZE, NUM_KER and DATA_W defaults.
  - The FSM state enum: IDLE, LOAD, PEND.
  - The slot index type, clog2(NUM_KER) bits.
- One sub-module, kernel_bank: NUM_KER × 9 register storage with a single whole-kernel write port and a registered 9-coefficient read port addressed by cur_sel.
- The FSM, counter and shadow buffer stay in kernel_bank_ctrl.

## Test plan
- Reset, then load slot 2 with bytes 1..9 continuously while frame_busy = 0 -> ld_ready high for exactly 9 cycles, ld_done pulses once, and frame_start with frm_sel = 2 gives k0..k8 = 1..9 with k_valid high one cycle later.
- cur_sel = 1 with frame_busy = 1, load slot 1 with 0xA0..0xA8 -> FSM stays in PEND, k0..k8 unchanged, no ld_done. Drop frame_busy -> bank written, ld_done pulses, k0 = 0xA0 one cycle later.
- Same busy frame, load slot 3 -> commit occurs immediately, and the cur_sel = 1 outputs never change.
- Random ld_valid gaps during a load, plus an ld_start issued during LOAD -> exactly 9 beats accepted in order, and the second ld_start is ignored.
- Assert rst after 5 beats -> all outputs 0 and the FSM in IDLE. A new full load of slot 0 with 0x11..0x19 then reads back exactly, with no residue from the aborted load.
- PEND commit to slot 0 coincident with frame_start, frm_sel = 0 -> k0..k8 show the new kernel at F+1.
